// File: rtl/regmst_apb_map_pkg.sv
// Shared types and helpers for the APB register master (regmst_apb_map).
package regmst_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    TMO  = 3'd4
  } regmst_state_e;

  // Fill bit for prdata on errored, misaligned and write completions.
  localparam logic PRDATA_ERR_BIT = 1'b0;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/regmst_apb_map_tmo_cnt.sv
// Wait-cycle counter for regmst_apb_map; expire flags the last permitted WAIT cycle.
module regmst_tmo_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Holding at LAST keeps the counter from wrapping even if en stays high.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/regmst_apb_map.sv
// APB3 slave that serialises host accesses onto reg_native_if with a wait timeout.
// Optional sticky error log enabled by defining REGMST_APB_MAP_ERR_CAPTURE_EN.
module regmst_apb_map
  import regmst_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      regmst_apb_map_clk,
  input  logic                      regmst_apb_map_rst_n,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      regmst_apb_map__downstream__req_vld,
  input  logic                      downstream__regmst_apb_map__ack_vld,
  input  logic                      downstream__regmst_apb_map__err,
  output logic [ADDR_WIDTH-1:0]     regmst_apb_map__downstream__addr,
  output logic                      regmst_apb_map__downstream__wr_en,
  output logic                      regmst_apb_map__downstream__rd_en,
  output logic [DATA_WIDTH-1:0]     regmst_apb_map__downstream__wr_data,
  input  logic [DATA_WIDTH-1:0]     downstream__regmst_apb_map__rd_data,
  output logic                      regmst_apb_map__downstream__soft_rst
`ifdef REGMST_APB_MAP_ERR_CAPTURE_EN
  ,
  output logic                      err_log_vld,
  output logic [ADDR_WIDTH-1:0]     err_log_addr
`endif
);

  // Handshake: req_vld is a one-cycle strobe (the REQ state); ack_vld with err/rd_data
  // is accepted only in REQ or WAIT and is ignored in every other state.

  localparam logic [DATA_WIDTH-1:0] PRDATA_ERR = {DATA_WIDTH{PRDATA_ERR_BIT}};

  regmst_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic                  req_vld_q, req_vld_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  soft_rst_q, soft_rst_d;
  logic                  expire;
  logic                  ack;

  assign ack = downstream__regmst_apb_map__ack_vld;

  regmst_tmo_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo_cnt (
    .clk_i   (regmst_apb_map_clk),
    .rst_ni  (regmst_apb_map_rst_n),
    .clr_i   (state_q == REQ),
    .en_i    (state_q == WAIT),
    .expire_o(expire)
  );

  // Output registers are loaded from the next-state decision so every output is a flop.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    pwrite_d   = pwrite_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = PRDATA_ERR;
    req_vld_d  = 1'b0;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    soft_rst_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          addr_d   = ADDR_WIDTH'(paddr);
          wdata_d  = pwdata;
          pwrite_d = pwrite;
          if (is_misaligned(paddr[1:0])) begin
            state_d   = DONE;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else begin
            state_d   = REQ;
            req_vld_d = 1'b1;
            wr_en_d   = pwrite;
            rd_en_d   = !pwrite;
          end
        end
      end
      REQ, WAIT: begin
        if (ack) begin
          state_d   = DONE;
          pready_d  = 1'b1;
          pslverr_d = downstream__regmst_apb_map__err;
          prdata_d  = pwrite_q ? PRDATA_ERR : downstream__regmst_apb_map__rd_data;
        end else if (state_q == REQ) begin
          state_d = WAIT;
        end else if (expire) begin
          state_d    = TMO;
          pready_d   = 1'b1;
          pslverr_d  = 1'b1;
          soft_rst_d = 1'b1;
        end
      end
      DONE, TMO: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge regmst_apb_map_clk or negedge regmst_apb_map_rst_n) begin
    if (!regmst_apb_map_rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      pwrite_q   <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      req_vld_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      soft_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      pwrite_q   <= pwrite_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      req_vld_q  <= req_vld_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      soft_rst_q <= soft_rst_d;
    end
  end

  assign pready                               = pready_q;
  assign pslverr                              = pslverr_q;
  assign prdata                               = prdata_q;
  assign regmst_apb_map__downstream__req_vld  = req_vld_q;
  assign regmst_apb_map__downstream__addr     = addr_q;
  assign regmst_apb_map__downstream__wr_en    = wr_en_q;
  assign regmst_apb_map__downstream__rd_en    = rd_en_q;
  assign regmst_apb_map__downstream__wr_data  = wdata_q;
  assign regmst_apb_map__downstream__soft_rst = soft_rst_q;

`ifdef REGMST_APB_MAP_ERR_CAPTURE_EN
  logic                  err_log_vld_q;
  logic [ADDR_WIDTH-1:0] err_log_addr_q;

  // First errored completion wins; later errors leave the logged address alone.
  always_ff @(posedge regmst_apb_map_clk or negedge regmst_apb_map_rst_n) begin
    if (!regmst_apb_map_rst_n) begin
      err_log_vld_q  <= 1'b0;
      err_log_addr_q <= '0;
    end else if (!err_log_vld_q && pready_d && pslverr_d) begin
      err_log_vld_q  <= 1'b1;
      err_log_addr_q <= addr_d;
    end
  end

  assign err_log_vld  = err_log_vld_q;
  assign err_log_addr = err_log_addr_q;
`endif

endmodule
